cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Producer end of the 4-lane common data bus (CDB) that writes the physical register file and wakes up the reservation stations.
- Collects completed results from NUM_FU functional units through valid/ready handshakes.
- Buffers each unit's results in a small FIFO and grants up to CDB_W results per cycle, round-robin.
- Drives registered cdb_valid/cdb_tag/cdb_data lanes.

Parameters:
- NUM_FU, 6, number of functional-unit result ports.
- CDB_W, 4, CDB lanes (must match PRF write ports).
- TAG_W, 8, physical register tag width (256 PRs).
- DATA_W, 32, result width.
- FIFO_D, 2, per-unit buffer depth (power of 2, ≥2).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- flush  input  1  synchronous pipeline flush; discards all buffered results.
- fu_valid  input  NUM_FU  unit i presents a result.
- fu_tag  input  TAG_W x NUM_FU (unpacked [0:NUM_FU-1])  destination physical tag.
- fu_data  input  DATA_W x NUM_FU (unpacked)  result value.
- fu_ready  output  NUM_FU  unit i's FIFO can accept.
- cdb_valid  output  CDB_W  lane j carries a write.
- cdb_tag  output  TAG_W x CDB_W (unpacked [0:CDB_W-1])  lane tag.
- cdb_data  output  DATA_W x CDB_W (unpacked)  lane data.

Behaviour:
- Reset (reset=0, asynchronous):
  - All FIFOs empty; rr_ptr=0.
  - cdb_valid=0, cdb_tag=0, cdb_data=0.
  - fu_ready=all 1 once reset is released.
- Handshake:
  - fu_ready[i] = (count_i < FIFO_D), decoded from registered state only; no combinational path from fu_valid.
  - Push on fu_valid[i] && fu_ready[i] at the clock edge.
- Tag 0 (hard-wired zero register): the result is accepted (handshake completes) and dropped. It is never stored or broadcast.
- Arbitration, combinational on registered FIFO state:
  - Scan units rr_ptr, rr_ptr+1, … mod NUM_FU.
  - Grant the first min(CDB_W, nonempty count) nonempty FIFOs, at most one entry per FIFO per cycle.
  - The k-th grant in scan order goes to lane k; lanes fill contiguously from 0 and unused lanes have cdb_valid=0.
- Output register:
  - Granted heads are popped and latched into cdb_* at the same edge.
  - Latency: a result accepted at edge k is broadcast no earlier than the cycle after edge k+1, i.e. minimum 1 cycle of buffering, then 1 cycle valid on the CDB.
  - Each cdb lane is valid for exactly one cycle per result.
- Pointer update:
  - If ≥1 grant: rr_ptr ← (index of last granted unit + 1) mod NUM_FU.
  - If no grant: unchanged.
  - Guarantees no starvation; every nonempty FIFO is served within ceil(NUM_FU/CDB_W) cycles.
- Simultaneous push/pop on the same FIFO in one cycle is allowed: count unchanged, FIFO order preserved.
- A full FIFO shows ready=0 and cannot push, even if it is popped in that cycle. fu_ready rises the cycle after the pop.
- Per-unit ordering is FIFO. No ordering is guaranteed across units.
- flush=1 at an edge:
  - All FIFOs are emptied; pushes and pops in that cycle are discarded.
  - cdb_valid ← 0 next cycle; rr_ptr ← 0.
  - flush has priority over everything except reset.
- Reset asserted mid-operation: all state is cleared immediately and in-flight results are lost (the core is also being reset).
- Pointer wrap-around is mod NUM_FU; FIFO pointers wrap mod FIFO_D with an extra bit for full/empty.
- Unit-level tag uniqueness is the rename stage's responsibility and is not checked here.

Decomposition:
- Shared package cdb_pkg:
  - TAG_W, DATA_W, CDB_W constants.
  - cdb_lane_t typedef {valid, tag, data}.
  - ZERO_TAG constant (8'd0).
  - The same package is used by the PRF and reservation stations.
- One natural sub-module: res_fifo (parameterised FIFO_D x (TAG_W+DATA_W), with push/pop/count/full/empty and synchronous clear), instantiated NUM_FU times.
- The arbiter scan and output register stay in cdb_arbiter.

Test Plan:
- Reset, then single result: fu_valid[2]=1, tag=8'h15, data=32'hDEADBEEF for one cycle → exactly one cycle later cdb_valid=4'b0001, cdb_tag[0]=8'h15, cdb_data[0]=32'hDEADBEEF. Outputs are 0 during and after reset.
- All 6 units push once in the same cycle (tags 1..6), rr_ptr=0:
  - Cycle A: lanes 0..3 = tags 1,2,3,4.
  - Cycle A+1: lanes 0..1 = tags 5,6 and cdb_valid=4'b0011.
  - rr_ptr ends at 0.
- Backpressure: unit 0 pushes continuously while units 1..5 hold 2 entries each:
  - fu_ready[0] drops to 0 after 2 accepted entries.
  - Every unit is granted within 2 cycles (no starvation).
  - Per-unit order is preserved.
- Tag 0 drop: unit 1 pushes tag 0 data 32'h1234 → handshake completes and no cdb_valid appears in the following 3 cycles.
- Flush: 5 results buffered, then flush=1 for one cycle → cdb_valid=0 the next cycle and stays 0, all fu_ready=1, rr_ptr=0.
- Async reset mid-burst: drop reset between clock edges while cdb_valid=4'b1111 → cdb_valid=0 immediately (before the next edge) and all FIFOs are empty after release.

Source files
------------

// File: rtl/cdb_pkg.sv
// Common data bus definitions shared by the CDB arbiter, the physical register file and the reservation stations.
package cdb_pkg;
    localparam int TAG_W  = 8;
    localparam int DATA_W = 32;
    localparam int CDB_W  = 4;

    // Physical register 0 is hard-wired to zero; results aimed at it are never broadcast.
    localparam logic [TAG_W-1:0] ZERO_TAG = 8'd0;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_lane_t;
endpackage

// File: rtl/res_fifo.sv
// Small per-unit result FIFO: wrap-around pointers with an extra bit to tell full from empty.
module res_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/cdb_arbiter.sv
// Collects functional-unit results into per-unit FIFOs and broadcasts up to CDB_W of them per cycle, round-robin.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU = 6,
    parameter int FIFO_D = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [NUM_FU-1:0] fu_valid,
    input  logic [TAG_W-1:0]  fu_tag   [0:NUM_FU-1],
    input  logic [DATA_W-1:0] fu_data  [0:NUM_FU-1],
    output logic [NUM_FU-1:0] fu_ready,
    output logic [CDB_W-1:0]  cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag  [0:CDB_W-1],
    output logic [DATA_W-1:0] cdb_data [0:CDB_W-1]
);
    localparam int FU_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int LANE_W  = (CDB_W > 1) ? $clog2(CDB_W) : 1;
    localparam int CNT_W   = $clog2(CDB_W + 1);
    localparam int ENTRY_W = TAG_W + DATA_W;
    localparam int FCNT_W  = $clog2(FIFO_D) + 1;

    logic [ENTRY_W-1:0] head  [0:NUM_FU-1];
    logic [FCNT_W-1:0]  count [0:NUM_FU-1];
    logic [NUM_FU-1:0]  full;
    logic [NUM_FU-1:0]  empty;
    logic [NUM_FU-1:0]  push;
    logic [NUM_FU-1:0]  pop;
    logic [NUM_FU-1:0]  grant;

    logic [FU_W-1:0]    rr_ptr_reg;
    logic [FU_W-1:0]    rr_ptr_next;
    cdb_lane_t          lane_reg  [0:CDB_W-1];
    cdb_lane_t          lane_next [0:CDB_W-1];

    logic [FU_W:0]      scan_sum;
    logic [FU_W-1:0]    scan_idx;
    logic [FU_W-1:0]    last_idx;
    logic [CNT_W-1:0]   n_grant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
            // Zero-tag results complete the handshake but are never stored.
            assign push[gi]     = fu_valid[gi] && !full[gi] && (fu_tag[gi] != ZERO_TAG) && !flush;
            assign pop[gi]      = grant[gi] && !flush;
            assign fu_ready[gi] = (count[gi] < FCNT_W'(FIFO_D));

            res_fifo #(
                .DEPTH (FIFO_D),
                .WIDTH (ENTRY_W)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .clear (flush),
                .push  (push[gi]),
                .pop   (pop[gi]),
                .din   ({fu_tag[gi], fu_data[gi]}),
                .dout  (head[gi]),
                .count (count[gi]),
                .full  (full[gi]),
                .empty (empty[gi])
            );
        end
    endgenerate

    // Rotating scan from rr_ptr; the k-th nonempty unit found lands on lane k.
    always_comb begin
        grant    = '0;
        n_grant  = '0;
        last_idx = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int j = 0; j < CDB_W; j++) lane_next[j] = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_sum = {1'b0, rr_ptr_reg} + (FU_W+1)'(k);
            if (scan_sum >= (FU_W+1)'(NUM_FU)) scan_sum = scan_sum - (FU_W+1)'(NUM_FU);
            scan_idx = scan_sum[FU_W-1:0];
            if (!empty[scan_idx] && (n_grant < CNT_W'(CDB_W))) begin
                grant[scan_idx]                  = 1'b1;
                lane_next[n_grant[LANE_W-1:0]]   = '{valid: 1'b1,
                                                     tag:   head[scan_idx][ENTRY_W-1 -: TAG_W],
                                                     data:  head[scan_idx][DATA_W-1:0]};
                last_idx = scan_idx;
                n_grant  = n_grant + CNT_W'(1);
            end
        end
        rr_ptr_next = rr_ptr_reg;
        if (n_grant != '0)
            rr_ptr_next = (last_idx == FU_W'(NUM_FU - 1)) ? '0 : last_idx + FU_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg <= '0;
            for (int j = 0; j < CDB_W; j++) lane_reg[j] <= '0;
        end else if (flush) begin
            rr_ptr_reg <= '0;
            for (int j = 0; j < CDB_W; j++) lane_reg[j] <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            lane_reg   <= lane_next;
        end
    end

    generate
        for (gi = 0; gi < CDB_W; gi++) begin : g_lane
            assign cdb_valid[gi] = lane_reg[gi].valid;
            assign cdb_tag[gi]   = lane_reg[gi].tag;
            assign cdb_data[gi]  = lane_reg[gi].data;
        end
    endgenerate
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised scoreboard bench: a queue-level reference model predicts each cycle's CDB lanes and ready flags.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NF = 6;
    localparam int D  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic [NF-1:0]     fu_valid = '0;
    logic [TAG_W-1:0]  fu_tag   [0:NF-1];
    logic [DATA_W-1:0] fu_data  [0:NF-1];
    logic [NF-1:0]     fu_ready;
    logic [CDB_W-1:0]  cdb_valid;
    logic [TAG_W-1:0]  cdb_tag  [0:CDB_W-1];
    logic [DATA_W-1:0] cdb_data [0:CDB_W-1];

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_FU(NF), .FIFO_D(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_data   (fu_data),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    typedef struct packed {
        logic [CDB_W-1:0]             v;
        logic [CDB_W-1:0][TAG_W-1:0]  tag;
        logic [CDB_W-1:0][DATA_W-1:0] data;
        logic [NF-1:0]                rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: per-unit queues of {tag,data} plus the round-robin start unit.
    logic [TAG_W+DATA_W-1:0] mq [0:NF-1][0:D-1];
    int                      msz [0:NF-1];
    int                      mrr;

    // Pending stimulus, applied at the next falling edge by tick().
    logic [NF-1:0]     p_valid = '0;
    logic [TAG_W-1:0]  p_tag  [0:NF-1];
    logic [DATA_W-1:0] p_data [0:NF-1];
    logic              p_flush = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int u = 0; u < NF; u++) msz[u] = 0;
        mrr = 0;
    endtask

    task automatic model_step(output exp_t e);
        int n;
        int last;
        int u;
        logic [NF-1:0] rdy_before;
        e = '0;
        if (flush) begin
            model_clear();
        end else begin
            n = 0;
            last = 0;
            for (int i = 0; i < NF; i++) rdy_before[i] = (msz[i] < D);
            for (int k = 0; k < NF; k++) begin
                u = (mrr + k) % NF;
                if (msz[u] > 0 && n < CDB_W) begin
                    e.v[n]    = 1'b1;
                    e.tag[n]  = mq[u][0][TAG_W+DATA_W-1:DATA_W];
                    e.data[n] = mq[u][0][DATA_W-1:0];
                    mq[u][0]  = mq[u][1];
                    msz[u]    = msz[u] - 1;
                    last      = u;
                    n++;
                end
            end
            for (int i = 0; i < NF; i++) begin
                if (fu_valid[i] && rdy_before[i] && fu_tag[i] != 8'd0) begin
                    mq[i][msz[i]] = {fu_tag[i], fu_data[i]};
                    msz[i] = msz[i] + 1;
                end
            end
            if (n > 0) mrr = (last + 1) % NF;
        end
        for (int i = 0; i < NF; i++) e.rdy[i] = (msz[i] < D);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        fu_valid = p_valid;
        flush    = p_flush;
        for (int i = 0; i < NF; i++) begin
            fu_tag[i]  = p_tag[i];
            fu_data[i] = p_data[i];
        end
        model_step(e);
        exp_q.push_back(e);
        p_valid = '0;
        p_flush = 1'b0;
    endtask

    task automatic set_unit(input int u, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        p_valid[u] = 1'b1;
        p_tag[u]   = t;
        p_data[u]  = d;
    endtask

    // Monitor: compares the DUT after each rising edge against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (cdb_valid !== e.v || fu_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL lanes_ready: valid=%b ready=%b expected valid=%b ready=%b",
                             cdb_valid, fu_ready, e.v, e.rdy);
                end
                for (int j = 0; j < CDB_W; j++) begin
                    if (e.v[j]) begin
                        checks++;
                        if (cdb_tag[j] !== e.tag[j] || cdb_data[j] !== e.data[j]) begin
                            errors++;
                            $display("FAIL lane%0d: tag=%h data=%h expected tag=%h data=%h",
                                     j, cdb_tag[j], cdb_data[j], e.tag[j], e.data[j]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit found;
        for (int i = 0; i < NF; i++) begin
            fu_tag[i] = '0; fu_data[i] = '0; p_tag[i] = '0; p_data[i] = '0;
        end
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tags", 64'({cdb_tag[0], cdb_tag[1], cdb_tag[2], cdb_tag[3]}), 64'd0);
        chk("rst_data0", 64'(cdb_data[0]), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_ready", 64'(fu_ready), 64'h3F);

        // All six units push in one cycle, tags 1..6
        for (int u = 0; u < NF; u++) set_unit(u, 8'(u + 1), $urandom);
        tick();
        tick();
        @(posedge clk); #1;
        chk("all6_a_valid", 64'(cdb_valid), 64'hF);
        chk("all6_a_tags", 64'({cdb_tag[0], cdb_tag[1], cdb_tag[2], cdb_tag[3]}), 64'h01020304);
        tick();
        @(posedge clk); #1;
        chk("all6_b_valid", 64'(cdb_valid), 64'h3);
        chk("all6_b_tags", 64'({cdb_tag[0], cdb_tag[1]}), 64'h0506);

        // Single result on unit 2
        set_unit(2, 8'h15, 32'hDEADBEEF);
        tick();
        tick();
        @(posedge clk); #1;
        chk("single_valid", 64'(cdb_valid), 64'h1);
        chk("single_tag", 64'(cdb_tag[0]), 64'h15);
        chk("single_data", 64'(cdb_data[0]), 64'hDEADBEEF);
        tick();
        @(posedge clk); #1;
        chk("single_once", 64'(cdb_valid), 64'h0);

        // Backpressure: unit 0 streams, units 1..5 get two entries each
        for (int c = 0; c < 8; c++) begin
            set_unit(0, 8'($urandom_range(1, 255)), $urandom);
            if (c < 2)
                for (int u = 1; u < NF; u++) set_unit(u, 8'($urandom_range(1, 255)), $urandom);
            tick();
        end
        repeat (6) tick();

        // Tag 0 is accepted and dropped
        set_unit(1, 8'd0, 32'h1234);
        tick();
        repeat (4) tick();

        // Flush with five results buffered
        for (int u = 0; u < 5; u++) set_unit(u, 8'($urandom_range(1, 255)), $urandom);
        tick();
        p_flush = 1'b1;
        tick();
        repeat (4) tick();

        // Randomised traffic with occasional flushes and zero tags
        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < NF; u++) begin
                if ($urandom_range(0, 1) == 1)
                    set_unit(u, ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255)), $urandom);
            end
            if ($urandom_range(0, 49) == 0) p_flush = 1'b1;
            tick();
        end
        repeat (4) tick();

        // Asynchronous reset while all four lanes are busy
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (c < 3)
                for (int u = 0; u < NF; u++) set_unit(u, 8'($urandom_range(1, 255)), $urandom);
            tick();
            if (exp_q.size() > 0 && exp_q[exp_q.size() - 1].v == 4'hF) found = 1'b1;
        end
        chk("burst_reached", 64'(found), 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        fu_valid = '0;
        flush = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        chk("async_rst_valid", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 64'(fu_ready), 64'h3F);
        repeat (4) tick();

        // Let the monitor consume every prediction, bounded
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
        #3;
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
